// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// Multi-cycle main control FSM for the MIPS core: sequences fetch, decode, execute,
// memory and write-back, and drives the datapath control bus from the latched opcode.
module multicycle_control #(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        memReady,
  output logic [1:0]  regDst,
  output logic [1:0]  jump,
  output logic [1:0]  branch,
  output logic        memRead,
  output logic [1:0]  memToReg,
  output logic [2:0]  aluOp,
  output logic        memWrite,
  output logic        aluSrc,
  output logic        regWrite,
  output logic [1:0]  extType,
  output logic        pcWrite,
  output logic        irWrite,
  output logic        illegal,
  output logic        memErr
);

  localparam int unsigned CNT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (FETCH_TIMEOUT == 0) ? '0 : CNT_W'(FETCH_TIMEOUT - 1);
  localparam bit TMO_EN = (FETCH_TIMEOUT != 0);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  typedef enum logic [3:0] {
    K_RALU, K_JR, K_ADDIU, K_ORI, K_LUI, K_LW, K_SW,
    K_BEQ, K_BNE, K_J, K_JAL, K_ILL
  } kind_t;

  state_t           state;
  state_t           state_next;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic [CNT_W-1:0] cnt;
  kind_t            kind;
  logic [2:0]       r_alu;
  logic             waiting;
  logic             tmo;
  logic             unused_ir_bits;

  // Only opcode and funct feed the control decode.
  assign unused_ir_bits = ^instruction[25:6];

  assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !memReady;
  assign tmo     = TMO_EN && waiting && (cnt == CNT_LAST);

  // Instruction class from the latched opcode/funct.
  always_comb begin
    kind  = K_ILL;
    r_alu = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin kind = K_RALU; r_alu = ALU_ADD; end
          FN_SUBU: begin kind = K_RALU; r_alu = ALU_SUB; end
          FN_AND:  begin kind = K_RALU; r_alu = ALU_AND; end
          FN_OR:   begin kind = K_RALU; r_alu = ALU_OR;  end
          FN_SLT:  begin kind = K_RALU; r_alu = ALU_SLT; end
          FN_JR:   kind = K_JR;
          default: kind = K_ILL;
        endcase
      end
      OP_ADDIU: kind = K_ADDIU;
      OP_ORI:   kind = K_ORI;
      OP_LUI:   kind = K_LUI;
      OP_LW:    kind = K_LW;
      OP_SW:    kind = K_SW;
      OP_BEQ:   kind = K_BEQ;
      OP_BNE:   kind = K_BNE;
      OP_J:     kind = K_J;
      OP_JAL:   kind = K_JAL;
      default:  kind = K_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  // Opcode latch and memory wait counter; the counter restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op    <= '0;
      funct <= '0;
      cnt   <= '0;
    end else begin
      if (state == S_DECODE) begin
        op    <= instruction[31:26];
        funct <= instruction[5:0];
      end
      if ((state_next != state) || tmo) cnt <= '0;
      else if (waiting)                 cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (memReady) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        case (kind)
          K_RALU, K_ADDIU, K_ORI, K_LUI, K_JAL: state_next = S_WB;
          K_LW, K_SW:                          state_next = S_MEM;
          default:                             state_next = S_FETCH;
        endcase
      end
      S_MEM:    if (memReady) state_next = (kind == K_LW) ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Control bus decode; everything is forced low while reset is held.
  always_comb begin
    regDst   = 2'b00;
    jump     = 2'b00;
    branch   = 2'b00;
    memRead  = 1'b0;
    memToReg = 2'b00;
    aluOp    = ALU_ADD;
    memWrite = 1'b0;
    aluSrc   = 1'b0;
    regWrite = 1'b0;
    extType  = 2'b00;
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    illegal  = 1'b0;
    memErr   = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          memRead = 1'b1;
          irWrite = memReady;
          pcWrite = memReady;
          memErr  = tmo;
        end
        S_EXEC: begin
          case (kind)
            K_RALU:  aluOp = r_alu;
            K_ADDIU: begin aluSrc = 1'b1; extType = 2'b01; aluOp = ALU_ADD; end
            K_ORI:   begin aluSrc = 1'b1; extType = 2'b00; aluOp = ALU_OR;  end
            K_LUI:   begin aluSrc = 1'b1; extType = 2'b10; aluOp = ALU_LUI; end
            K_LW, K_SW: begin aluSrc = 1'b1; extType = 2'b01; aluOp = ALU_ADD; end
            K_BEQ:   begin aluOp = ALU_SUB; branch = 2'b01; extType = 2'b01; end
            K_BNE:   begin aluOp = ALU_SUB; branch = 2'b10; extType = 2'b01; end
            K_J, K_JAL: jump = 2'b01;
            K_JR:    jump = 2'b10;
            default: illegal = 1'b1;
          endcase
        end
        S_MEM: begin
          memRead  = (kind == K_LW);
          memWrite = (kind == K_SW);
          aluSrc   = 1'b1;
          extType  = 2'b01;
          aluOp    = ALU_ADD;
          memErr   = tmo;
        end
        S_WB: begin
          regWrite = 1'b1;
          case (kind)
            K_RALU:  regDst = 2'b01;
            K_LW:    memToReg = 2'b01;
            K_JAL:   begin regDst = 2'b10; memToReg = 2'b10; end
            default: regDst = 2'b00;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
// Bench for multicycle_control: a per-instruction trace model predicts the control
// bus every cycle, plus literal spot checks on the captured DUT trace.
module tb_multicycle_control;

  localparam int unsigned TMO = 4;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] jump;
    logic [1:0] branch;
    logic       mem_read;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] ext_type;
    logic       pc_write;
    logic       ir_write;
    logic       illegal;
    logic       mem_err;
  } ctl_t;

  typedef struct packed {
    ctl_t ex;
    ctl_t wb;
    logic mem;
    logic lw;
    logic wb_en;
  } info_t;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        memReady;
  logic [1:0]  regDst, jump, branch, memToReg, extType;
  logic [2:0]  aluOp;
  logic        memRead, memWrite, aluSrc, regWrite, pcWrite, irWrite, illegal, memErr;

  ctl_t  dut_v;
  ctl_t  exp_v;
  logic  exp_valid;
  string tag;
  ctl_t  hist[$];
  int    nvec;
  int    nerr;

  multicycle_control #(.FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .memReady(memReady),
    .regDst(regDst), .jump(jump), .branch(branch), .memRead(memRead),
    .memToReg(memToReg), .aluOp(aluOp), .memWrite(memWrite), .aluSrc(aluSrc),
    .regWrite(regWrite), .extType(extType), .pcWrite(pcWrite), .irWrite(irWrite),
    .illegal(illegal), .memErr(memErr)
  );

  assign dut_v = {regDst, jump, branch, memRead, memToReg, aluOp, memWrite,
                  aluSrc, regWrite, extType, pcWrite, irWrite, illegal, memErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Per-cycle comparison against the model; also records the DUT trace.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_valid) begin
        nvec++;
        hist.push_back(dut_v);
        if (dut_v !== exp_v) begin
          nerr++;
          $display("FAIL %s[%0d]: dut=%h model=%h", tag, hist.size() - 1, dut_v, exp_v);
        end
      end
    end
  end

  // Expected EXEC and WB control for a given instruction word.
  function automatic info_t model(input logic [31:0] w);
    info_t m;
    logic [5:0] op;
    logic [5:0] fn;
    m  = '0;
    op = w[31:26];
    fn = w[5:0];
    m.wb.reg_write = 1'b1;
    case (op)
      6'h00: begin
        case (fn)
          6'h21, 6'h23, 6'h24, 6'h25, 6'h2A: begin
            m.wb_en = 1'b1;
            m.wb.reg_dst = 2'b01;
            m.ex.alu_op = (fn == 6'h21) ? 3'd0 : (fn == 6'h23) ? 3'd1 :
                          (fn == 6'h24) ? 3'd2 : (fn == 6'h25) ? 3'd3 : 3'd4;
          end
          6'h08:   m.ex.jump = 2'b10;
          default: m.ex.illegal = 1'b1;
        endcase
      end
      6'h09: begin m.ex.alu_src = 1'b1; m.ex.ext_type = 2'b01; m.ex.alu_op = 3'd0; m.wb_en = 1'b1; end
      6'h0D: begin m.ex.alu_src = 1'b1; m.ex.ext_type = 2'b00; m.ex.alu_op = 3'd3; m.wb_en = 1'b1; end
      6'h0F: begin m.ex.alu_src = 1'b1; m.ex.ext_type = 2'b10; m.ex.alu_op = 3'd5; m.wb_en = 1'b1; end
      6'h23: begin
        m.ex.alu_src = 1'b1; m.ex.ext_type = 2'b01;
        m.mem = 1'b1; m.lw = 1'b1; m.wb_en = 1'b1; m.wb.mem_to_reg = 2'b01;
      end
      6'h2B: begin m.ex.alu_src = 1'b1; m.ex.ext_type = 2'b01; m.mem = 1'b1; end
      6'h04: begin m.ex.alu_op = 3'd1; m.ex.branch = 2'b01; m.ex.ext_type = 2'b01; end
      6'h05: begin m.ex.alu_op = 3'd1; m.ex.branch = 2'b10; m.ex.ext_type = 2'b01; end
      6'h02: m.ex.jump = 2'b01;
      6'h03: begin
        m.ex.jump = 2'b01; m.wb_en = 1'b1;
        m.wb.reg_dst = 2'b10; m.wb.mem_to_reg = 2'b10;
      end
      default: m.ex.illegal = 1'b1;
    endcase
    return m;
  endfunction

  function automatic ctl_t mem_vec(input logic lw);
    ctl_t e;
    e = '0;
    e.mem_read  = lw;
    e.mem_write = !lw;
    e.alu_src   = 1'b1;
    e.ext_type  = 2'b01;
    return e;
  endfunction

  // k-th consecutive wait cycle (1-based) reports a timeout every TMO waits.
  function automatic logic err_at(input int k);
    return (TMO != 0) && ((k % int'(TMO)) == 0);
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int count_of(input int f);
    int n;
    n = 0;
    foreach (hist[i]) begin
      case (f)
        0:       n += hist[i].mem_read  ? 1 : 0;
        1:       n += hist[i].mem_err   ? 1 : 0;
        2:       n += hist[i].reg_write ? 1 : 0;
        3:       n += hist[i].ir_write  ? 1 : 0;
        4:       n += hist[i].illegal   ? 1 : 0;
        5:       n += hist[i].mem_write ? 1 : 0;
        default: n += hist[i].pc_write  ? 1 : 0;
      endcase
    end
    return n;
  endfunction

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: dut=%0h expected=%0h", name, act, want);
    end
  endtask

  task automatic cyc(input ctl_t e, input logic rdy, input logic [31:0] ir);
    memReady    = rdy;
    instruction = ir;
    exp_v       = e;
    exp_valid   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_phase(input int fw);
    ctl_t e;
    for (int k = 1; k <= fw; k++) begin
      e = '0;
      e.mem_read = 1'b1;
      e.mem_err  = err_at(k);
      cyc(e, 1'b0, $urandom());
    end
    e = '0;
    e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    cyc(e, 1'b1, $urandom());
  endtask

  task automatic run_instr(input string name, input logic [31:0] w, input int fw, input int mw);
    info_t m;
    ctl_t  e;
    tag = name;
    hist.delete();
    m = model(w);
    fetch_phase(fw);
    cyc('0, rnd(), w);
    cyc(m.ex, rnd(), w);
    if (m.mem) begin
      e = mem_vec(m.lw);
      for (int k = 1; k <= mw; k++) begin
        e.mem_err = err_at(k);
        cyc(e, 1'b0, w);
      end
      e.mem_err = 1'b0;
      cyc(e, 1'b1, w);
    end
    if (m.wb_en) cyc(m.wb, rnd(), w);
  endtask

  initial begin
    ctl_t e;
    nvec = 0;
    nerr = 0;
    exp_valid = 1'b0;
    exp_v = '0;
    tag = "reset";
    rst = 1'b0;
    memReady = 1'b1;
    instruction = 32'h0;
    #12;
    pin("reset_outputs", 32'(dut_v), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run_instr("addu", 32'h00221821, 0, 0);
    pin("addu_wb_ctl", 32'({hist[3].reg_write, hist[3].reg_dst, hist[3].mem_to_reg}), 32'h14);
    pin("addu_irwrite_count", 32'(count_of(3)), 32'd1);
    pin("addu_pcwrite_count", 32'(count_of(6)), 32'd1);

    run_instr("subu", 32'h00221823, 1, 0);
    run_instr("and",  32'h00221824, 0, 0);
    run_instr("or",   32'h00221825, 2, 0);
    run_instr("slt",  32'h0022182A, 0, 0);

    run_instr("lw", 32'h8C220004, 3, 2);
    pin("lw_memread_count", 32'(count_of(0)), 32'd7);
    pin("lw_wb_ctl", 32'({hist[9].mem_to_reg, hist[9].reg_dst}), 32'h4);
    pin("lw_no_memerr", 32'(count_of(1)), 32'd0);

    run_instr("beq", 32'h10220003, 0, 0);
    pin("beq_branch", 32'(hist[2].branch), 32'd1);
    pin("beq_aluop", 32'(hist[2].alu_op), 32'd1);
    pin("beq_no_regwrite", 32'(count_of(2)), 32'd0);
    run_instr("bne", 32'h14220003, 0, 0);
    pin("bne_branch", 32'(hist[2].branch), 32'd2);

    run_instr("jal", 32'h0C000010, 0, 0);
    pin("jal_exec_jump", 32'(hist[2].jump), 32'd1);
    pin("jal_wb_ctl", 32'({hist[3].reg_dst, hist[3].mem_to_reg, hist[3].reg_write}), 32'h15);

    run_instr("illegal_op3f", 32'hFC000000, 0, 0);
    pin("illegal_count", 32'(count_of(4)), 32'd1);
    pin("illegal_in_exec", 32'(hist[2].illegal), 32'd1);
    pin("illegal_no_writes", 32'(count_of(2) + count_of(5)), 32'd0);
    run_instr("after_illegal", 32'h00221821, 0, 0);
    run_instr("illegal_funct20", 32'h00221820, 0, 0);

    run_instr("addiu", 32'h24220005, 0, 0);
    run_instr("ori",   32'h3422000F, 0, 0);
    run_instr("lui",   32'h3C021234, 0, 0);
    run_instr("sw",    32'hAC220008, 1, 5);
    pin("sw_mem_timeout_count", 32'(count_of(1)), 32'd1);
    run_instr("j",     32'h08000010, 0, 0);
    run_instr("jr",    32'h03E00008, 0, 0);

    run_instr("fetch_timeout", 32'h00221821, 12, 0);
    pin("fetch_memerr_count", 32'(count_of(1)), 32'd3);

    // Abort a store while it is waiting in MEM.
    tag = "sw_abort";
    hist.delete();
    fetch_phase(0);
    cyc('0, 1'b0, 32'hAC220008);
    cyc(model(32'hAC220008).ex, 1'b0, 32'hAC220008);
    e = mem_vec(1'b0);
    cyc(e, 1'b0, 32'hAC220008);
    exp_valid = 1'b0;
    memReady = 1'b0;
    #1;
    pin("sw_memwrite_before_reset", 32'(memWrite), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    pin("sw_abort_outputs", 32'(dut_v), 32'd0);
    memReady = 1'b1;
    @(posedge clk);
    #1;
    pin("reset_hold_outputs", 32'(dut_v), 32'd0);
    rst = 1'b1;
    run_instr("post_reset_addu", 32'h00221821, 0, 0);
    pin("post_reset_no_memwrite", 32'(count_of(5)), 32'd0);

    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the MIPS core; the producer side of the datapath control bus.
- Consumes the 32-bit instruction word from the datapath's instruction register.
- Drives every datapath control input, plus PC/IR write enables, per state.
- Handles memory wait states via a ready handshake on fetch and data access.

Parameters:
- FETCH_TIMEOUT, 16, max cycles FETCH/MEM may wait on memReady before `memErr` pulses. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- instruction  in  32  IR contents from datapath; valid from DECODE onward
- memReady  in  1  memory completes the current access this cycle
- regDst  out  2  00 rt, 01 rd, 10 $31
- jump  out  2  00 none, 01 j/jal target, 10 jr (rs)
- branch  out  2  00 none, 01 beq, 10 bne
- memRead  out  1  memory read request
- memToReg  out  2  00 ALU, 01 memory, 10 PC+4
- aluOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 lui
- memWrite  out  1  memory write request
- aluSrc  out  1  0 register, 1 extended immediate
- regWrite  out  1  register file write enable
- extType  out  2  00 zero, 01 sign, 10 upper-16
- pcWrite  out  1  unconditional PC update
- irWrite  out  1  IR load enable
- illegal  out  1  one-cycle pulse on an undecodable instruction
- memErr  out  1  one-cycle pulse on a memReady timeout

Behaviour:
- Reset (rst=0, asynchronous): state <= FETCH, latched op/funct <= 0, wait counter <= 0. All outputs 0 while reset is asserted. The next cycle after release begins a fresh fetch.
- States: FETCH, DECODE, EXEC, MEM, WB.
- Outputs are decoded combinationally from the state register and the latched op/funct only, never directly from `instruction`. Any output not listed for the current state is 0.
- FETCH:
  - memRead=1.
  - When memReady=1: irWrite=1, pcWrite=1 (PC<=PC+4), then go to DECODE.
  - Otherwise hold in FETCH and increment the wait counter.
- DECODE:
  - Latch op=instruction[31:26] and funct=instruction[5:0].
  - Go to EXEC; always exactly one cycle.
- Decode set:
  - R-type (op 0): addu 21h, subu 23h, and 24h, or 25h, slt 2Ah, jr 08h.
  - I-type: addiu 09h, ori 0Dh, lui 0Fh, lw 23h, sw 2Bh.
  - Branch: beq 04h, bne 05h.
  - Jump: j 02h, jal 03h.
  - Anything else: pulse illegal in EXEC, assert no control, return to FETCH (treated as nop).
- EXEC:
  - R-type ALU ops: aluSrc=0, aluOp per funct; next WB.
  - addiu: aluSrc=1, extType=01, aluOp=000; next WB.
  - ori: aluSrc=1, extType=00, aluOp=011; next WB.
  - lui: aluSrc=1, extType=10, aluOp=101; next WB.
  - lw/sw: aluSrc=1, extType=01, aluOp=000; next MEM.
  - beq/bne: aluOp=001, branch=01/10, extType=01; next FETCH.
  - j: jump=01; next FETCH.
  - jal: jump=01; next WB.
  - jr: jump=10; next FETCH.
- MEM:
  - lw holds memRead=1; sw holds memWrite=1. Hold aluSrc=1, extType=01, aluOp=000 so the address stays stable.
  - When memReady=1: lw goes to WB, sw goes to FETCH. Otherwise wait.
- WB:
  - regWrite=1 for one cycle, then FETCH.
  - R-type: regDst=01, memToReg=00.
  - Immediate ALU ops: regDst=00, memToReg=00.
  - lw: regDst=00, memToReg=01.
  - jal: regDst=10, memToReg=10.
- Latency, with memReady=1 in the first cycle of each wait state:
  - branch/j/jr: 3 cycles.
  - R-type/immediate/sw/jal: 4 cycles.
  - lw: 5 cycles.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - When it reaches FETCH_TIMEOUT with memReady still 0: pulse memErr, clear the counter, remain in the same state and keep retrying.
- Simultaneous events: memReady arriving on the same cycle as a timeout means completion wins; memErr is not pulsed.
- Reset asserted mid-instruction aborts the instruction; no partial regWrite or memWrite may follow the reset release.

Test Plan:
- addu (op 0, funct 21h), memReady always 1:
  - Required states: FETCH, DECODE, EXEC, WB.
  - WB cycle: regWrite=1, regDst=01, memToReg=00; irWrite/pcWrite only in cycle 1.
- lw 8C220004 with memReady low for 3 cycles in FETCH and 2 in MEM:
  - memRead held throughout both waits.
  - Total 10 cycles; WB has memToReg=01, regDst=00.
- beq, then bne:
  - EXEC shows branch=01, aluOp=001, then branch=10.
  - Each returns to FETCH after 3 cycles; regWrite never asserted.
- jal 0C000010:
  - EXEC jump=01.
  - WB: regDst=10, memToReg=10, regWrite=1.
- Opcode 3Fh:
  - illegal pulses exactly one cycle in EXEC; no write enables asserted.
  - Next instruction fetches normally.
- FETCH_TIMEOUT=4 with memReady stuck at 0:
  - memErr pulses every 4 wait cycles.
- sw mid-MEM: drive rst low; memWrite drops to 0 immediately (asynchronous), and FETCH follows release.
